// File: rtl/video_stream_to_window.sv
// Raster stream to per-lane WIN_SIZE x WIN_SIZE causal neighbourhoods.
// Stage 1 reads the line buffers; stage 2 assembles clamped windows and registers them.
module video_stream_to_window #(
  parameter int PX_WIDTH      = 12,
  parameter int PX_PER_CLK    = 4,
  parameter int WIN_SIZE      = 3,
  parameter int MAX_LINE_SIZE = 1936
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
  input  logic [PX_PER_CLK*PX_WIDTH-1:0]                  px_data_i,
  input  logic [PX_PER_CLK-1:0]                           px_data_val_i,
  input  logic                                            line_start_i,
  input  logic                                            line_end_i,
  input  logic                                            frame_start_i,
  input  logic                                            frame_end_i,
  output logic [PX_PER_CLK*WIN_SIZE*WIN_SIZE*PX_WIDTH-1:0] win_data_o,
  output logic [PX_PER_CLK-1:0]                           win_data_val_o,
  output logic                                            frame_start_o,
  output logic                                            frame_end_o,
  output logic                                            line_start_o,
  output logic                                            line_end_o
);
  localparam int NBUF   = WIN_SIZE - 1;
  localparam int DEPTH  = (MAX_LINE_SIZE + PX_PER_CLK - 1) / PX_PER_CLK;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW     = (NBUF > 1) ? $clog2(NBUF) : 1;
  localparam int RW     = $clog2(WIN_SIZE);
  localparam int EXT    = NBUF + PX_PER_CLK;
  localparam int WORD_W = PX_PER_CLK * PX_WIDTH;

  logic              active_s;
  logic [AW-1:0]     addr_s, addr_r;
  logic [RW-1:0]     row_s, row_r;
  logic [SW-1:0]     sel_r;
  logic [WORD_W-1:0] mem [NBUF][DEPTH];
  logic [WORD_W-1:0] rd_r [NBUF];

  logic [WORD_W-1:0]     s1_data_r;
  logic [PX_PER_CLK-1:0] s1_val_r;
  logic                  s1_fs_r, s1_fe_r, s1_ls_r, s1_le_r;
  logic [RW-1:0]         s1_row_r;
  logic [SW-1:0]         s1_sel_r;

  logic [PX_WIDTH-1:0] hist_r [WIN_SIZE][NBUF];
  logic [PX_WIDTH-1:0] raw_s  [WIN_SIZE][PX_PER_CLK];
  logic [PX_WIDTH-1:0] ext_s  [WIN_SIZE][EXT];
  logic [PX_PER_CLK*WIN_SIZE*WIN_SIZE*PX_WIDTH-1:0] win_s;
  int                  lim_s;

  // Word address and row count as seen by the incoming word.
  always_comb begin
    active_s = |px_data_val_i;
    if (line_start_i) begin
      addr_s = '0;
    end else begin
      addr_s = addr_r;
    end
    if (frame_start_i) begin
      row_s = '0;
    end else begin
      row_s = row_r;
    end
  end

  // Line-buffer write pointer, saturating row counter and buffer-role rotation.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      addr_r <= '0;
      row_r  <= '0;
      sel_r  <= '0;
    end else if (active_s) begin
      addr_r <= (addr_s != AW'(DEPTH - 1)) ? addr_s + AW'(1) : addr_s;
      row_r  <= (line_end_i && (row_s != RW'(WIN_SIZE - 1))) ? row_s + RW'(1) : row_s;
      if (line_end_i) begin
        sel_r <= (sel_r == SW'(NBUF - 1)) ? '0 : sel_r + SW'(1);
      end
    end
  end

  // Line memories: buffer sel_r takes the current line while every buffer is read (old data).
  always_ff @(posedge clk_i) begin
    if (active_s) begin
      for (int b = 0; b < NBUF; b++) begin
        rd_r[b] <= mem[b][addr_s];
        if (sel_r == SW'(b)) begin
          mem[b][addr_s] <= px_data_i;
        end
      end
    end
  end

  // Stage 1 word, mask, flags and row context; inactive words carry no flags.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1_data_r <= '0;
      s1_val_r  <= '0;
      s1_fs_r   <= 1'b0;
      s1_fe_r   <= 1'b0;
      s1_ls_r   <= 1'b0;
      s1_le_r   <= 1'b0;
      s1_row_r  <= '0;
      s1_sel_r  <= '0;
    end else begin
      s1_data_r <= px_data_i;
      s1_val_r  <= active_s ? px_data_val_i : '0;
      s1_fs_r   <= active_s & frame_start_i;
      s1_fe_r   <= active_s & frame_end_i;
      s1_ls_r   <= active_s & line_start_i;
      s1_le_r   <= active_s & line_end_i;
      s1_row_r  <= row_s;
      s1_sel_r  <= sel_r;
    end
  end

  // Raw rows oldest-first: buffer (sel + r) holds line y-(WIN_SIZE-1)+r, last row is the live word.
  always_comb begin
    for (int r = 0; r < WIN_SIZE; r++) begin
      for (int k = 0; k < PX_PER_CLK; k++) begin
        if (r == NBUF) begin
          raw_s[r][k] = s1_data_r[k*PX_WIDTH +: PX_WIDTH];
        end else begin
          raw_s[r][k] = rd_r[(int'(s1_sel_r) + r) % NBUF][k*PX_WIDTH +: PX_WIDTH];
        end
      end
    end
  end

  // Extended rows: column history ahead of the word; at line start history replicates column 0.
  always_comb begin
    for (int r = 0; r < WIN_SIZE; r++) begin
      for (int j = 0; j < NBUF; j++) begin
        if (s1_ls_r) begin
          ext_s[r][j] = raw_s[r][0];
        end else begin
          ext_s[r][j] = hist_r[r][j];
        end
      end
      for (int k = 0; k < PX_PER_CLK; k++) begin
        ext_s[r][NBUF + k] = raw_s[r][k];
      end
    end
  end

  // Window gather; rows older than the frame fall back to the frame's first line.
  always_comb begin
    win_s = '0;
    lim_s = NBUF - int'(s1_row_r);
    for (int l = 0; l < PX_PER_CLK; l++) begin
      for (int r = 0; r < WIN_SIZE; r++) begin
        for (int c = 0; c < WIN_SIZE; c++) begin
          win_s[((l*WIN_SIZE + r)*WIN_SIZE + c)*PX_WIDTH +: PX_WIDTH] =
            ext_s[(r > lim_s) ? r : lim_s][l + c];
        end
      end
    end
  end

  // Output registers and per-row column history.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      win_data_o     <= '0;
      win_data_val_o <= '0;
      frame_start_o  <= 1'b0;
      frame_end_o    <= 1'b0;
      line_start_o   <= 1'b0;
      line_end_o     <= 1'b0;
      for (int r = 0; r < WIN_SIZE; r++) begin
        for (int j = 0; j < NBUF; j++) begin
          hist_r[r][j] <= '0;
        end
      end
    end else begin
      win_data_val_o <= s1_val_r;
      frame_start_o  <= s1_fs_r;
      frame_end_o    <= s1_fe_r;
      line_start_o   <= s1_ls_r;
      line_end_o     <= s1_le_r;
      if (|s1_val_r) begin
        win_data_o <= win_s;
        for (int r = 0; r < WIN_SIZE; r++) begin
          for (int j = 0; j < NBUF; j++) begin
            hist_r[r][j] <= ext_s[r][PX_PER_CLK + j];
          end
        end
      end else begin
        win_data_o <= '0;
      end
    end
  end
endmodule

// File: tb/tb_video_stream_to_window.sv
// Bench for video_stream_to_window: frame-level reference model (clamped pixel lookup)
// compared per output cycle, plus directed window probes from known pixel patterns.
module tb_video_stream_to_window;
  localparam int PXW  = 8;
  localparam int PPC  = 4;
  localparam int WS   = 3;
  localparam int WINW = WS * WS * PXW;

  logic                clk = 1'b0;
  logic                rst_i;
  logic [PPC*PXW-1:0]  px_data;
  logic [PPC-1:0]      px_val;
  logic                ls, le, fs, fe;
  logic [PPC*WINW-1:0] win_data;
  logic [PPC-1:0]      win_val;
  logic                fs_o, fe_o, ls_o, le_o;

  always #5 clk = ~clk;

  video_stream_to_window #(
    .PX_WIDTH(PXW), .PX_PER_CLK(PPC), .WIN_SIZE(WS), .MAX_LINE_SIZE(16)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .px_data_i(px_data), .px_data_val_i(px_val),
    .line_start_i(ls), .line_end_i(le), .frame_start_i(fs), .frame_end_i(fe),
    .win_data_o(win_data), .win_data_val_o(win_val),
    .frame_start_o(fs_o), .frame_end_o(fe_o), .line_start_o(ls_o), .line_end_o(le_o)
  );

  typedef struct {
    logic [3:0]          val;
    logic [3:0]          flags;
    logic [PPC*WINW-1:0] win;
    int                  y;
    int                  x0;
    logic [3:0]          got_val;
    logic [3:0]          got_flags;
    logic [PPC*WINW-1:0] got_win;
  } rec_t;

  rec_t            expq[$];
  rec_t            rec_q[$];
  logic [7:0]      pix [16][16];
  logic [WINW-1:0] cap [16][16];
  int              my = 0, mx = 0;
  int              errors = 0, checks = 0;

  function automatic logic [WINW-1:0] ref_win(input int y, input int x);
    logic [WINW-1:0] w;
    int yy, xx;
    for (int r = 0; r < WS; r++) begin
      for (int c = 0; c < WS; c++) begin
        yy = (y - (WS - 1) + r < 0) ? 0 : y - (WS - 1) + r;
        xx = (x - (WS - 1) + c < 0) ? 0 : x - (WS - 1) + c;
        w[(r*WS + c)*PXW +: PXW] = pix[yy][xx];
      end
    end
    return w;
  endfunction

  function automatic rec_t idle_rec();
    rec_t e;
    e.val = '0; e.flags = '0; e.win = '0; e.y = 0; e.x0 = 0;
    e.got_val = '0; e.got_flags = '0; e.got_win = '0;
    return e;
  endfunction

  // Drive one word, extend the model, then record the output due this cycle.
  task automatic step(input logic [PPC*PXW-1:0] d, input logic [3:0] v,
                      input logic s_ls, input logic s_le, input logic s_fs, input logic s_fe);
    rec_t e;
    e = idle_rec();
    px_data = d; px_val = v; ls = s_ls; le = s_le; fs = s_fs; fe = s_fe;
    if (v != 4'b0) begin
      if (s_fs) my = 0;
      if (s_ls) mx = 0;
      for (int l = 0; l < PPC; l++) if (v[l]) pix[my][mx+l] = d[l*PXW +: PXW];
      for (int l = 0; l < PPC; l++) if (v[l]) e.win[l*WINW +: WINW] = ref_win(my, mx + l);
      e.val = v; e.flags = {s_fs, s_fe, s_ls, s_le}; e.y = my; e.x0 = mx;
      mx += PPC;
      if (s_le && my < 15) my++;
    end
    expq.push_back(e);
    @(posedge clk); #1;
    e = expq.pop_front();
    e.got_val = win_val; e.got_flags = {fs_o, fe_o, ls_o, le_o}; e.got_win = win_data;
    for (int l = 0; l < PPC; l++) if (e.val[l]) cap[e.y][e.x0+l] = win_data[l*WINW +: WINW];
    rec_q.push_back(e);
  endtask

  task automatic idle(input bit junk);
    step(junk ? 32'($urandom) : 32'h0, 4'b0, junk & 1'($urandom), junk & 1'($urandom),
         junk & 1'($urandom), junk & 1'($urandom));
  endtask

  task automatic send_frame(input int w, input int h, input bit rnd, input bit fin, input int gap);
    int nw;
    logic [3:0] lastm;
    logic [PPC*PXW-1:0] d;
    nw = (w + PPC - 1) / PPC;
    lastm = 4'((1 << (w - PPC*(nw - 1))) - 1);
    for (int y = 0; y < h; y++) begin
      for (int k = 0; k < nw; k++) begin
        for (int l = 0; l < PPC; l++) d[l*PXW +: PXW] = rnd ? 8'($urandom) : 8'(16*y + PPC*k + l);
        if (rnd && $urandom_range(0, 3) == 0) idle(1'b1);
        step(d, (k == nw - 1) ? lastm : 4'hF, k == 0, k == nw - 1,
             (y == 0) && (k == 0), fin && (y == h - 1) && (k == nw - 1));
      end
      for (int g = 0; g < gap; g++) idle(rnd);
    end
  endtask

  task automatic clear_cap();
    for (int y = 0; y < 16; y++) for (int x = 0; x < 16; x++) cap[y][x] = 'x;
  endtask

  task automatic restart_pipe();
    expq.delete();
    expq.push_back(idle_rec());
  endtask

  task automatic test_reset();
    rst_i = 1'b0; px_data = '0; px_val = '0; ls = 0; le = 0; fs = 0; fe = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({win_data, win_val, fs_o, fe_o, ls_o, le_o} !== '0) begin
      errors++; $display("FAIL reset_state: got val=%b flags=%b%b%b%b want all zero",
                         win_val, fs_o, fe_o, ls_o, le_o);
    end
    rst_i = 1'b1;
    restart_pipe();
  endtask

  task automatic test_frame_pattern();
    clear_cap();
    send_frame(8, 4, 1'b0, 1'b1, 3);
    foreach (rec_q[i]) begin
      checks++;
      if ({rec_q[i].got_val, rec_q[i].got_flags} !== {rec_q[i].val, rec_q[i].flags}) begin
        errors++; $display("FAIL pattern_sync[%0d]: got val=%b flags=%b want val=%b flags=%b", i,
                           rec_q[i].got_val, rec_q[i].got_flags, rec_q[i].val, rec_q[i].flags);
      end
      for (int l = 0; l < PPC; l++) if (rec_q[i].val[l]) begin
        checks++;
        if (rec_q[i].got_win[l*WINW +: WINW] !== rec_q[i].win[l*WINW +: WINW]) begin
          errors++; $display("FAIL pattern_win[%0d] lane%0d: got %h want %h", i, l,
                             rec_q[i].got_win[l*WINW +: WINW], rec_q[i].win[l*WINW +: WINW]);
        end
      end
    end
    rec_q.delete();
    checks++;
    if (cap[0][0] !== 72'h0) begin
      errors++; $display("FAIL origin_lane0: got %h want 0", cap[0][0]);
    end
    checks++;
    if (cap[0][1] !== 72'h010000_010000_010000) begin
      errors++; $display("FAIL origin_lane1: got %h want 010000010000010000", cap[0][1]);
    end
    checks++;
    if (cap[1][0] !== 72'h101010_000000_000000) begin
      errors++; $display("FAIL row_clamp_y1: got %h want 101010000000000000", cap[1][0]);
    end
    checks++;
    if (cap[2][5] !== 72'h252423_151413_050403) begin
      errors++; $display("FAIL interior_y2_x5: got %h want 252423151413050403", cap[2][5]);
    end
    checks++;
    if (cap[3][7] !== 72'h373635_272625_171615) begin
      errors++; $display("FAIL interior_y3_x7: got %h want 373635272625171615", cap[3][7]);
    end
  endtask

  task automatic test_partial_line();
    clear_cap();
    send_frame(7, 3, 1'b0, 1'b1, 3);
    foreach (rec_q[i]) begin
      checks++;
      if ({rec_q[i].got_val, rec_q[i].got_flags} !== {rec_q[i].val, rec_q[i].flags}) begin
        errors++; $display("FAIL partial_sync[%0d]: got val=%b flags=%b want val=%b flags=%b", i,
                           rec_q[i].got_val, rec_q[i].got_flags, rec_q[i].val, rec_q[i].flags);
      end
      for (int l = 0; l < PPC; l++) if (rec_q[i].val[l]) begin
        checks++;
        if (rec_q[i].got_win[l*WINW +: WINW] !== rec_q[i].win[l*WINW +: WINW]) begin
          errors++; $display("FAIL partial_win[%0d] lane%0d: got %h want %h", i, l,
                             rec_q[i].got_win[l*WINW +: WINW], rec_q[i].win[l*WINW +: WINW]);
        end
      end
    end
    rec_q.delete();
    checks++;
    if (cap[1][6] !== 72'h161514_060504_060504) begin
      errors++; $display("FAIL partial_x6: got %h want 161514060504060504", cap[1][6]);
    end
    checks++;
    if (cap[2][0] !== 72'h202020_101010_000000) begin
      errors++; $display("FAIL next_line_clamp: got %h want 202020101010000000", cap[2][0]);
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 14; f++) begin
      send_frame($urandom_range(1, 16), $urandom_range(1, 6), 1'b1,
                 $urandom_range(0, 4) != 0, $urandom_range(0, 3));
    end
    idle(1'b1);
    foreach (rec_q[i]) begin
      checks++;
      if ({rec_q[i].got_val, rec_q[i].got_flags} !== {rec_q[i].val, rec_q[i].flags}) begin
        errors++; $display("FAIL random_sync[%0d]: got val=%b flags=%b want val=%b flags=%b", i,
                           rec_q[i].got_val, rec_q[i].got_flags, rec_q[i].val, rec_q[i].flags);
      end
      for (int l = 0; l < PPC; l++) if (rec_q[i].val[l]) begin
        checks++;
        if (rec_q[i].got_win[l*WINW +: WINW] !== rec_q[i].win[l*WINW +: WINW]) begin
          errors++; $display("FAIL random_win[%0d] lane%0d: got %h want %h", i, l,
                             rec_q[i].got_win[l*WINW +: WINW], rec_q[i].win[l*WINW +: WINW]);
        end
      end
    end
    rec_q.delete();
  endtask

  task automatic test_reset_midline();
    step(32'h03020100, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);
    step(32'h07060504, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({win_val, fs_o, ls_o} !== 6'b1111_11) begin
      errors++; $display("FAIL pre_reset_out: got val=%b fs=%b ls=%b want val=1111 fs=1 ls=1",
                         win_val, fs_o, ls_o);
    end
    rec_q.delete();
    #2 rst_i = 1'b0;
    #1;
    checks++;
    if ({win_data, win_val, fs_o, fe_o, ls_o, le_o} !== '0) begin
      errors++; $display("FAIL async_reset: got val=%b flags=%b%b%b%b want all zero",
                         win_val, fs_o, fe_o, ls_o, le_o);
    end
    @(posedge clk); #1;
    rst_i = 1'b1;
    restart_pipe();
    clear_cap();
    send_frame(8, 4, 1'b0, 1'b1, 3);
    foreach (rec_q[i]) begin
      checks++;
      if ({rec_q[i].got_val, rec_q[i].got_flags} !== {rec_q[i].val, rec_q[i].flags}) begin
        errors++; $display("FAIL post_reset_sync[%0d]: got val=%b flags=%b want val=%b flags=%b", i,
                           rec_q[i].got_val, rec_q[i].got_flags, rec_q[i].val, rec_q[i].flags);
      end
    end
    rec_q.delete();
    checks++;
    if (cap[0][0] !== 72'h0) begin
      errors++; $display("FAIL post_reset_lane0: got %h want 0", cap[0][0]);
    end
    checks++;
    if (cap[0][1] !== 72'h010000_010000_010000) begin
      errors++; $display("FAIL post_reset_lane1: got %h want 010000010000010000", cap[0][1]);
    end
  endtask

  initial begin
    test_reset();
    test_frame_pattern();
    test_partial_line();
    test_random_frames();
    test_reset_midline();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
